// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM chain: dead-time FSM state encoding and default widths.
package pwm_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_DT_RISE,
    S_HIGH,
    S_DT_FALL
  } t_dt_state;

  localparam int C_WIDTH_DEADTIME = 8;

endpackage

// File: rtl/pwm_deadtime.sv
// Splits a single PWM stream into a complementary high/low gate-drive pair with a
// programmable dead interval, enable gating and a latched fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int G_WIDTH_DEADTIME = C_WIDTH_DEADTIME
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [G_WIDTH_DEADTIME-1:0] deadtime_i,
  input  logic                        pwm_i,
  input  logic                        fault_i,
  input  logic                        fault_clr_i,
  output logic                        pwm_hi_o,
  output logic                        pwm_lo_o,
  output logic                        fault_latched_o
);

  localparam logic [G_WIDTH_DEADTIME-1:0] ONE  = {{(G_WIDTH_DEADTIME-1){1'b0}}, 1'b1};
  localparam logic [G_WIDTH_DEADTIME-1:0] ZERO = '0;

  t_dt_state                   state;
  t_dt_state                   state_nxt;
  logic [G_WIDTH_DEADTIME-1:0] cnt;
  logic [G_WIDTH_DEADTIME-1:0] cnt_nxt;
  logic                        fault_nxt;
  logic                        force_off;

  // A programmed dead time of 0 behaves as 1 cycle; the counter holds D-1.
  function automatic logic [G_WIDTH_DEADTIME-1:0] dead_load(
    input logic [G_WIDTH_DEADTIME-1:0] dt
  );
    return (dt == ZERO) ? ZERO : dt - ONE;
  endfunction

  function automatic logic [G_WIDTH_DEADTIME-1:0] dead_dec(
    input logic [G_WIDTH_DEADTIME-1:0] c
  );
    return (c == ZERO) ? ZERO : c - ONE;
  endfunction

  // The old latch value keeps the FSM in S_OFF on the clearing edge itself.
  assign force_off = fault_i | fault_latched_o | ~enable_i;
  assign fault_nxt = fault_i | (fault_latched_o & ~fault_clr_i);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_off) begin
      state_nxt = S_OFF;
    end else begin
      unique case (state)
        S_OFF: begin
          cnt_nxt   = dead_load(deadtime_i);
          state_nxt = pwm_i ? S_DT_RISE : S_DT_FALL;
        end
        S_LOW: begin
          if (pwm_i) begin
            cnt_nxt   = dead_load(deadtime_i);
            state_nxt = S_DT_RISE;
          end
        end
        S_DT_RISE: begin
          if (!pwm_i) begin
            cnt_nxt   = dead_load(deadtime_i);
            state_nxt = S_DT_FALL;
          end else if (cnt == ZERO) begin
            state_nxt = S_HIGH;
          end else begin
            cnt_nxt = dead_dec(cnt);
          end
        end
        S_HIGH: begin
          if (!pwm_i) begin
            cnt_nxt   = dead_load(deadtime_i);
            state_nxt = S_DT_FALL;
          end
        end
        S_DT_FALL: begin
          if (pwm_i) begin
            cnt_nxt   = dead_load(deadtime_i);
            state_nxt = S_DT_RISE;
          end else if (cnt == ZERO) begin
            state_nxt = S_LOW;
          end else begin
            cnt_nxt = dead_dec(cnt);
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= S_OFF;
      cnt             <= ZERO;
      fault_latched_o <= 1'b0;
      pwm_hi_o        <= 1'b0;
      pwm_lo_o        <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      fault_latched_o <= fault_nxt;
      pwm_hi_o        <= (state_nxt == S_HIGH);
      pwm_lo_o        <= (state_nxt == S_LOW);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboarded bench for pwm_deadtime: timestamp-based reference model, directed
// scenarios followed by randomized pwm/enable/fault/deadtime traffic.
module tb_pwm_deadtime;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [7:0] deadtime_i = 8'd0;
  logic       pwm_i = 1'b0;
  logic       fault_i = 1'b0;
  logic       fault_clr_i = 1'b0;
  logic       pwm_hi_o;
  logic       pwm_lo_o;
  logic       fault_latched_o;

  pwm_deadtime #(.G_WIDTH_DEADTIME(8)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .deadtime_i      (deadtime_i),
    .pwm_i           (pwm_i),
    .fault_i         (fault_i),
    .fault_clr_i     (fault_clr_i),
    .pwm_hi_o        (pwm_hi_o),
    .pwm_lo_o        (pwm_lo_o),
    .fault_latched_o (fault_latched_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  // Reference model: a transition starts at edge s with dead time dl; the target
  // level is driven once at least dl edges have passed since s.
  bit m_active = 1'b0;
  bit m_level  = 1'b0;
  int m_start  = 0;
  int m_dl     = 1;
  bit m_lat    = 1'b0;
  int m_edge   = 0;

  bit cur_p  = 1'b0;
  bit cur_en = 1'b1;
  int cur_dt = 4;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got hi/lo/flt=%b required %b", name, $time, act, req);
    end
  endtask

  task automatic step(input bit p, input bit en, input int dt, input bit f, input bit clr);
    bit off;
    bit lat_n;
    bit eh;
    bit el;
    @(negedge clk_i);
    reset_i     = 1'b0;
    pwm_i       = p;
    enable_i    = en;
    deadtime_i  = 8'(dt);
    fault_i     = f;
    fault_clr_i = clr;
    off   = f | m_lat | !en;
    lat_n = f | (m_lat & !clr);
    eh = 1'b0;
    el = 1'b0;
    if (off) begin
      m_active = 1'b0;
    end else if (!m_active || p != m_level) begin
      m_active = 1'b1;
      m_level  = p;
      m_start  = m_edge;
      m_dl     = (dt == 0) ? 1 : dt;
    end else if (m_edge - m_start >= m_dl) begin
      eh = m_level;
      el = !m_level;
    end
    m_lat = lat_n;
    m_edge++;
    exp_q.push_back({eh, el, lat_n});
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur_p, cur_en, cur_dt, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before the next clock edge.
  task automatic async_reset();
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset", {pwm_hi_o, pwm_lo_o, fault_latched_o}, 3'b000);
    m_active = 1'b0;
    m_lat    = 1'b0;
    m_edge++;
    exp_q.push_back(3'b000);
  endtask

  always begin
    logic [2:0] e;
    @(posedge clk_i);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", {pwm_hi_o, pwm_lo_o, fault_latched_o}, e);
      check("no_overlap", {2'b00, pwm_hi_o & pwm_lo_o}, 3'b000);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("reset_state", {pwm_hi_o, pwm_lo_o, fault_latched_o}, 3'b000);
    repeat (2) @(negedge clk_i);

    // T1: dead time 4, square wave with 100-cycle half period
    cur_dt = 4; cur_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cur_p = k[0];
      hold(100);
    end

    // T2: dead time 0 acts as a 1-cycle gap
    cur_dt = 0;
    for (int k = 0; k < 4; k++) begin
      cur_p = ~k[0];
      hold(10);
    end

    // T3: 2-cycle pulse shorter than a 10-cycle dead time is swallowed
    cur_dt = 10; cur_p = 1'b0; hold(20);
    cur_p = 1'b1; hold(2);
    cur_p = 1'b0; hold(20);

    // T4: fault pulse while high, simultaneous set/clear, then clear
    cur_dt = 3; cur_p = 1'b1; hold(15);
    step(1'b1, 1'b1, cur_dt, 1'b1, 1'b0);
    hold(6);
    step(1'b1, 1'b1, cur_dt, 1'b1, 1'b1);
    hold(3);
    step(1'b1, 1'b1, cur_dt, 1'b0, 1'b1);
    hold(10);

    // T5: enable drop mid-high, re-enable, then reset during a rising dead interval
    hold(5);
    cur_en = 1'b0; hold(5);
    cur_en = 1'b1; hold(12);
    cur_p = 1'b0; hold(10);
    cur_p = 1'b1; hold(2);
    async_reset();
    hold(15);

    // T6: steady low, steady high, dead time changed mid-interval
    cur_dt = 5; cur_p = 1'b0; hold(20);
    cur_p = 1'b1; hold(2);
    cur_dt = 9; hold(20);
    cur_p = 1'b0; hold(20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit f;
      bit clr;
      if ($urandom_range(0, 7) == 0) cur_p = ~cur_p;
      if ($urandom_range(0, 40) == 0) cur_dt = $urandom_range(0, 12);
      if ($urandom_range(0, 60) == 0) cur_en = ~cur_en;
      else if (!cur_en && $urandom_range(0, 3) == 0) cur_en = 1'b1;
      f   = ($urandom_range(0, 150) == 0);
      clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 400) == 0) async_reset();
      else step(cur_p, cur_en, cur_dt, f, clr);
    end

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 3'(exp_q.size()), 3'b000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
